mux_rr_arbiter: RTL
===================

// Module: mux_rr_arbiter
// PURPOSE
//   Round-robin burst arbiter that shares one Multiplexer output among NUM_INPUTS
//   requesters. It drives the mux's one-hot sel and handles the valid/ready handshake
//   between the granted requester and the single downstream consumer.
//   A grant is held for a whole burst, ending on the last beat or the MAX_BURST cap.
//   The block sits between the requester array and the mux/consumer pair.
// PARAMETERS
//   NUM_INPUTS  4   number of requesters; one sel bit per requester; must be >= 2
//   MAX_BURST   16  beats before a forced release; must be >= 1
//   IDW         $clog2(NUM_INPUTS)  width of grant_id (localparam, not overridable)
// PORTS
//   clk        in   1           rising-edge clock
//   rst_n      in   1           asynchronous active-low reset
//   req_valid  in   NUM_INPUTS  requester i has a beat available
//   req_last   in   NUM_INPUTS  requester i's current beat ends its burst
//   req_ready  out  NUM_INPUTS  beat of requester i is accepted this cycle
//   sel        out  NUM_INPUTS  one-hot mux select, registered; all zero when idle
//   grant_id   out  IDW         binary index of the current owner; 0 when idle
//   out_valid  out  1           downstream valid (owner's req_valid)
//   out_last   out  1           downstream last (owner's req_last, or forced on cap)
//   out_ready  in   1           downstream accepts the beat
//   busy       out  1           a grant is active (state == GRANT)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, sel=0, grant_id=0, ptr=0, beat_cnt=0.
//     Combinational outputs then follow: out_valid=0, out_last=0, req_ready=0, busy=0.
//   ptr is the priority pointer: the requester index with the highest priority.
//   IDLE:
//     - The winner is the first i with req_valid[i]=1, searching ptr, ptr+1, ...
//       modulo NUM_INPUTS.
//     - If there is a winner: on the next edge sel<=onehot(win), grant_id<=win,
//       beat_cnt<=0, state<=GRANT. Arbitration latency is 1 cycle.
//     - If no requester is valid: stay in IDLE with all outputs 0.
//   GRANT (owner o = grant_id):
//     - out_valid = req_valid[o].
//     - req_ready[o] = out_ready. req_ready[j] = 0 for every j != o.
//     - out_last = req_last[o] | (beat_cnt == MAX_BURST-1).
//     - A beat is accepted when out_valid & out_ready; beat_cnt then increments.
//     - Release happens when an accepted beat has out_last=1. On release:
//       state<=IDLE, sel<=0, grant_id<=0, ptr<=(o+1) mod NUM_INPUTS.
//       The next grant can be issued 1 cycle later (one bubble cycle per burst).
//     - The owner may drop req_valid mid-burst. The grant is held, no beat transfers,
//       and no timeout applies.
//     - Changes on req_valid/req_last of non-owners are ignored until IDLE.
//   Combinational paths: out_valid, out_last and req_ready depend combinationally on
//     the registered sel/grant_id and on req_valid, req_last and out_ready.
//     sel and grant_id have no combinational input path.
//   Invariants:
//     - sel is always zero or one-hot; $onehot0(sel) holds every cycle.
//     - At most one req_ready bit is set.
//     - beat_cnt never exceeds MAX_BURST-1.
//   Reset mid-burst: the grant is dropped immediately and asynchronously.
//     ptr returns to 0, so the partially sent burst is abandoned.
//   Fairness: with every requester continuously valid, the grant order is
//     0,1,...,N-1,0,...
// TESTING
//   T1 reset: rst_n=0 with all req_valid=1 -> sel=0, req_ready=0, busy=0,
//     out_valid=0 throughout reset.
//   T2 single requester: req_valid=4'b0100, 3-beat burst, last on beat 3,
//     out_ready=1 -> sel=4'b0100 one cycle after the request.
//     Exactly 3 transfers. Back to IDLE after beat 3; ptr=3.
//   T3 round robin: req_valid=4'b1111, all bursts 1 beat, out_ready=1 ->
//     grant sequence 0,1,2,3,0 with one idle cycle between grants.
//   T4 backpressure: owner 1 with out_ready low for 5 cycles mid-burst ->
//     sel stays 4'b0010 and beat_cnt frozen; the burst completes after out_ready
//     rises again.
//   T5 cap: MAX_BURST=4, requester 2 never asserts last ->
//     out_last=1 on the 4th accepted beat, then forced release and ptr=3.
//   T6 async reset mid-burst: rst_n pulses low between edges during beat 2 of
//     owner 3 -> sel=0 immediately. After reset, with all valid, the next grant
//     goes to requester 0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter driving a one-hot mux select and the
// valid/ready handshake between the owning requester and one consumer.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req_valid/req_last   per-requester beat valid / end-of-burst
//   req_ready            per-requester accept (owner only)
//   sel                  registered one-hot mux select, 0 when idle
//   grant_id             registered owner index, 0 when idle
//   out_valid/out_last   downstream beat valid / last (cap-forced)
//   out_ready            downstream accept
//   busy                 a grant is active

module mux_rr_arbiter #(
  parameter  int NUM_INPUTS = 4,
  parameter  int MAX_BURST  = 16,
  localparam int IDW        = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] req_valid,
  input  logic [NUM_INPUTS-1:0] req_last,
  output logic [NUM_INPUTS-1:0] req_ready,
  output logic [NUM_INPUTS-1:0] sel,
  output logic [IDW-1:0]        grant_id,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_INPUTS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [NUM_INPUTS-1:0] sel_q;
  logic [NUM_INPUTS-1:0] sel_d;
  logic [IDW-1:0]        gid_q;
  logic [IDW-1:0]        gid_d;
  logic [IDW-1:0]        ptr_q;
  logic [IDW-1:0]        ptr_d;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;

  logic                  found;
  logic [IDW-1:0]        win;
  logic                  own_valid;
  logic                  own_last;
  logic                  accept;

  // Rotating priority search starting at ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_INPUTS;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign busy      = (state_q == GRANT);
  assign own_valid = busy & req_valid[gid_q];
  assign own_last  = busy & (req_last[gid_q] | (cnt_q == CAP));
  assign accept    = own_valid & out_ready;

  assign out_valid = own_valid;
  assign out_last  = own_last;
  assign sel       = sel_q;
  assign grant_id  = gid_q;

  // Only the owner sees ready; sel_q is already one-hot on the owner.
  assign req_ready = busy && out_ready ? sel_q : '0;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = NUM_INPUTS'(1) << win;
          gid_d   = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          if (own_last) begin
            state_d = IDLE;
            sel_d   = '0;
            gid_d   = '0;
            ptr_d   = (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        gid_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
